mvm_controller: RTL and testbench

MVM_CONTROLLER -- requirements
Module: mvm_controller

---
 rtl/mvm_if.sv | 33 +++
 rtl/mvm_controller.sv | 158 +++++++++++++++
 tb/tb_mvm_controller.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mvm_if.sv
// Control bundle between the matrix-vector sequencer and its buffers/datapath.
// The master side is the sequencer; the slave side is the buffers, datapath and host.
interface mvm_if #(
  parameter int N = 4
);
  localparam int AW = $clog2(N);

  logic            start;
  logic            hold;
  logic            wr_en_x;
  logic [2*AW-1:0] addr_x;
  logic            wr_en_a;
  logic [AW-1:0]   addr_a;
  logic            mac_en;
  logic            clear_acc;
  logic            wr_en_y;
  logic [AW-1:0]   addr_y;
  logic            out_valid;
  logic            busy;
  logic            done;

  modport master (
    input  start, hold,
    output wr_en_x, addr_x, wr_en_a, addr_a, mac_en, clear_acc,
           wr_en_y, addr_y, out_valid, busy, done
  );

  modport slave (
    output start, hold,
    input  wr_en_x, addr_x, wr_en_a, addr_a, mac_en, clear_acc,
           wr_en_y, addr_y, out_valid, busy, done
  );
endinterface

// File: rtl/mvm_controller.sv
// Sequencer for an N x N matrix-vector multiply: load matrix, load vector,
// row-by-row multiply-accumulate with result write-back, then unload results.
module mvm_controller #(
  parameter int N = 4
) (
  input logic   clk,
  input logic   reset,
  mvm_if.master bus
);
  localparam int AW = $clog2(N);
  localparam int CW = 2 * AW;
  localparam logic [CW-1:0] LAST_X = CW'(N * N - 1);
  localparam logic [AW-1:0] LAST   = AW'(N - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_X, LOAD_A, COMPUTE, WRITE_Y, UNLOAD, DONE
  } state_t;

  state_t        state, adv_state, sel_state;
  logic [CW-1:0] cnt, adv_cnt, sel_cnt;
  logic          stalled;
  logic          sel_gate;
  logic          en;

  function automatic logic is_active(input state_t s);
    return (s != IDLE) && (s != DONE);
  endfunction

  // In COMPUTE/WRITE_Y the counter is {row, col}, so N*r+j is the counter itself.
  always_comb begin
    adv_state = state;
    adv_cnt   = cnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          adv_state = LOAD_X;
          adv_cnt   = '0;
        end
      end
      LOAD_X: begin
        if (cnt == LAST_X) begin
          adv_state = LOAD_A;
          adv_cnt   = '0;
        end else begin
          adv_cnt = cnt + CW'(1);
        end
      end
      LOAD_A: begin
        if (cnt[AW-1:0] == LAST) begin
          adv_state = COMPUTE;
          adv_cnt   = '0;
        end else begin
          adv_cnt = cnt + CW'(1);
        end
      end
      COMPUTE: begin
        if (cnt[AW-1:0] == LAST) adv_state = WRITE_Y;
        else                     adv_cnt   = cnt + CW'(1);
      end
      WRITE_Y: begin
        if (cnt[CW-1:AW] == LAST) begin
          adv_state = UNLOAD;
          adv_cnt   = '0;
        end else begin
          adv_state = COMPUTE;
          adv_cnt   = cnt + CW'(1);
        end
      end
      UNLOAD: begin
        if (cnt[AW-1:0] == LAST) begin
          adv_state = DONE;
          adv_cnt   = '0;
        end else begin
          adv_cnt = cnt + CW'(1);
        end
      end
      DONE: begin
        adv_state = IDLE;
        adv_cnt   = '0;
      end
      default: begin
        adv_state = IDLE;
        adv_cnt   = '0;
      end
    endcase

    // A step presented while hold is high is shown with enables off and
    // re-presented (enabled, not advanced) once hold drops.
    if (stalled) begin
      sel_state = state;
      sel_cnt   = cnt;
    end else begin
      sel_state = adv_state;
      sel_cnt   = adv_cnt;
    end
    sel_gate = bus.hold && is_active(sel_state);
    en       = !sel_gate;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      stalled       <= 1'b0;
      bus.wr_en_x   <= 1'b0;
      bus.addr_x    <= '0;
      bus.wr_en_a   <= 1'b0;
      bus.addr_a    <= '0;
      bus.mac_en    <= 1'b0;
      bus.clear_acc <= 1'b0;
      bus.wr_en_y   <= 1'b0;
      bus.addr_y    <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state         <= sel_state;
      cnt           <= sel_cnt;
      stalled       <= sel_gate;
      bus.wr_en_x   <= 1'b0;
      bus.addr_x    <= '0;
      bus.wr_en_a   <= 1'b0;
      bus.addr_a    <= '0;
      bus.mac_en    <= 1'b0;
      bus.clear_acc <= 1'b0;
      bus.wr_en_y   <= 1'b0;
      bus.addr_y    <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= (sel_state != IDLE);
      bus.done      <= (sel_state == DONE);
      case (sel_state)
        LOAD_X: begin
          bus.wr_en_x <= en;
          bus.addr_x  <= sel_cnt;
        end
        LOAD_A: begin
          bus.wr_en_a <= en;
          bus.addr_a  <= sel_cnt[AW-1:0];
        end
        COMPUTE: begin
          bus.mac_en    <= en;
          bus.clear_acc <= en && (sel_cnt[AW-1:0] == '0);
          bus.addr_x    <= sel_cnt;
          bus.addr_a    <= sel_cnt[AW-1:0];
        end
        WRITE_Y: begin
          bus.wr_en_y <= en;
          bus.addr_y  <= sel_cnt[CW-1:AW];
        end
        UNLOAD: begin
          bus.out_valid <= en;
          bus.addr_y    <= sel_cnt[AW-1:0];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mvm_controller.sv
// Directed bench for mvm_controller (N=4): full run, hold stall, ignored and
// held start, mid-run reset, checked cycle by cycle against a spec timeline.
module tb_mvm_controller;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mvm_if #(.N(N)) bus();

  mvm_controller #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // [15]busy [14]done [13]out_valid [12]wr_en_y [11:10]addr_y [9]mac_en
  // [8]clear_acc [7]wr_en_a [6:5]addr_a [4]wr_en_x [3:0]addr_x
  logic [15:0] obs;
  logic [15:0] tr [0:199];
  localparam logic [15:0] EN_MASK  = 16'h3290;
  localparam logic [15:0] ALL_ENAB = 16'h3390;

  assign obs = {bus.busy, bus.done, bus.out_valid, bus.wr_en_y, bus.addr_y,
                bus.mac_en, bus.clear_acc, bus.wr_en_a, bus.addr_a,
                bus.wr_en_x, bus.addr_x};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs for cycle n of an unstalled run (cycle 1 follows the start edge).
  function automatic logic [15:0] exp_vec(input int n);
    logic [15:0] v;
    int k, r, j;
    v = '0;
    if (n >= 1 && n <= 45) v[15] = 1'b1;
    if (n == 45) v[14] = 1'b1;
    if (n >= 1 && n <= 16) begin
      v[4]   = 1'b1;
      v[3:0] = 4'(n - 1);
    end else if (n >= 17 && n <= 20) begin
      v[7]   = 1'b1;
      v[6:5] = 2'(n - 17);
    end else if (n >= 21 && n <= 40) begin
      k = n - 21;
      r = k / 5;
      j = k % 5;
      if (j < 4) begin
        v[9]   = 1'b1;
        v[8]   = (j == 0);
        v[3:0] = 4'(4 * r + j);
        v[6:5] = 2'(j);
      end else begin
        v[12]    = 1'b1;
        v[11:10] = 2'(r);
      end
    end else if (n >= 41 && n <= 44) begin
      v[13]    = 1'b1;
      v[11:10] = 2'(n - 41);
    end
    return v;
  endfunction

  task automatic run(input int len, input int hold_from, input int hold_len,
                     input int pulse_at, input bit held);
    bus.start = 1'b1;
    bus.hold  = 1'b0;
    tick();
    tr[1] = obs;
    for (int n = 1; n < len; n++) begin
      bus.start = held || (n == pulse_at);
      bus.hold  = (n >= hold_from) && (n < hold_from + hold_len);
      tick();
      tr[n + 1] = obs;
    end
    bus.start = 1'b0;
    bus.hold  = 1'b0;
  endtask

  task automatic scan(input string name, input int len, input int first_done, input int n_done);
    int cnt;
    int first;
    cnt   = 0;
    first = 0;
    for (int n = 1; n <= len; n++) begin
      check($sformatf("%s_onehot_c%0d", name, n), 16'($onehot0(tr[n] & EN_MASK)), 16'd1);
      if (tr[n][14]) begin
        cnt++;
        if (first == 0) first = n;
      end
    end
    check({name, "_done_cycle"}, 16'(first), 16'(first_done));
    check({name, "_done_count"}, 16'(cnt), 16'(n_done));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    reset     = 1'b0;
    tick();
    tick();
    check("reset_outputs", obs, 16'h0000);
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.hold  = 1'b1;
    #0;
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    tick();
    check("idle_after_release", obs, 16'h0000);

    // Plain run.
    run(46, 0, 0, 0, 1'b0);
    for (int n = 1; n <= 46; n++) check($sformatf("plain_c%0d", n), tr[n], exp_vec(n));
    check("row2_first_addr_x",  16'(tr[31][3:0]), 16'd8);
    check("row2_first_clear",   16'(tr[31][8]),   16'd1);
    check("row2_last_addr_x",   16'(tr[34][3:0]), 16'd11);
    check("row2_last_clear",    16'(tr[34][8]),   16'd0);
    check("row2_wr_y_addr",     16'(tr[35][11:10]), 16'd2);
    scan("plain", 46, 45, 1);

    // Hold for three edges while addr_x=7 is pending.
    tick();
    run(49, 7, 3, 0, 1'b0);
    for (int n = 1; n <= 49; n++) begin
      if (n <= 7)       check($sformatf("hold_c%0d", n), tr[n], exp_vec(n));
      else if (n <= 10) check($sformatf("hold_c%0d", n), tr[n], exp_vec(8) & ~ALL_ENAB);
      else              check($sformatf("hold_c%0d", n), tr[n], exp_vec(n - 3));
    end
    scan("hold", 49, 48, 1);

    // Start re-pulsed mid-run is ignored.
    tick();
    run(50, 0, 0, 20, 1'b0);
    for (int n = 1; n <= 50; n++) check($sformatf("repulse_c%0d", n), tr[n], exp_vec(n));
    scan("repulse", 50, 45, 1);

    // Start held high: back-to-back runs through one IDLE cycle.
    tick();
    run(92, 0, 0, 0, 1'b1);
    for (int n = 1; n <= 45; n++) check($sformatf("b2b_a_c%0d", n), tr[n], exp_vec(n));
    check("b2b_idle_gap", tr[46], 16'h0000);
    for (int n = 47; n <= 91; n++) check($sformatf("b2b_b_c%0d", n), tr[n], exp_vec(n - 46));
    check("b2b_after", tr[92], 16'h0000);
    scan("b2b", 92, 45, 2);
    check("b2b_second_done", 16'(tr[91][14]), 16'd1);

    // Reset during COMPUTE row 1, then a fresh run.
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (26) tick();
    check("pre_reset_row1", obs, exp_vec(27));
    reset = 1'b0;
    bus.start = 1'b1;
    bus.hold  = 1'b1;
    tick();
    check("mid_reset_outputs", obs, 16'h0000);
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    tick();
    check("post_reset_idle", obs, 16'h0000);
    run(46, 0, 0, 0, 1'b0);
    for (int n = 1; n <= 46; n++) check($sformatf("fresh_c%0d", n), tr[n], exp_vec(n));
    scan("fresh", 46, 45, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
